// File: rtl/booth_r4_pp_accum_pkg.sv
// Shared definitions for the radix-4 Booth partial-product accumulator:
// Booth digit codes, which match the encoder side, and the FSM state type.
package booth_r4_pp_accum_pkg;

    localparam logic [2:0] BOOTH_0  = 3'b000;
    localparam logic [2:0] BOOTH_P1 = 3'b001;
    localparam logic [2:0] BOOTH_P2 = 3'b010;
    localparam logic [2:0] BOOTH_N1 = 3'b111;
    localparam logic [2:0] BOOTH_N2 = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/booth_r4_pp_accum_dec.sv
// Combinational radix-4 Booth digit decoder.
// Maps one 3-bit digit and an unsigned multiplicand to a signed partial product
// (0, +-A, +-2A) in PWIDTH bits. Illegal codes decode to 0 and raise 'illegal'.
module booth_dec_r4 #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned PWIDTH = 51
) (
    input  logic [2:0]        digit,
    input  logic [WIDTH-1:0]  a,
    output logic [PWIDTH-1:0] pp,
    output logic              illegal
);
    import booth_r4_pp_accum_pkg::*;

    logic [PWIDTH-1:0] a1;
    logic [PWIDTH-1:0] a2;

    assign a1 = {{(PWIDTH-WIDTH){1'b0}}, a};
    assign a2 = {a1[PWIDTH-2:0], 1'b0};

    // Select the partial product; negatives are formed as two's complement in PWIDTH bits.
    always_comb begin
        pp      = '0;
        illegal = 1'b0;
        unique case (digit)
            BOOTH_0:  pp = '0;
            BOOTH_P1: pp = a1;
            BOOTH_P2: pp = a2;
            BOOTH_N1: pp = ~a1 + PWIDTH'(1);
            BOOTH_N2: pp = ~a2 + PWIDTH'(1);
            default: begin
                pp      = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/booth_r4_pp_accum.sv
// Radix-4 Booth partial-product accumulator.
// Accepts a multiplicand and NDIG Booth digits, then accumulates one digit per
// cycle, most significant first: acc = acc*4 + pp(digit). Fixed latency of NDIG
// run cycles; the result is held in DONE until the downstream handshake.
module booth_r4_pp_accum #(
    parameter  int unsigned WIDTH  = 24,
    parameter  int unsigned NDIG   = WIDTH/2 + 1,
    localparam int unsigned PWIDTH = WIDTH + 2*NDIG + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [3*NDIG-1:0]   dig,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PWIDTH-1:0]   product,
    output logic                err
);
    import booth_r4_pp_accum_pkg::*;

    localparam int unsigned CW = $clog2(NDIG);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]         a_q, a_d;
    logic [NDIG-1:0][2:0]     dig_q, dig_d;
    logic [PWIDTH-1:0]        acc_q, acc_d;
    logic                     err_q, err_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic [2:0]               cur_digit;
    logic [PWIDTH-1:0]        pp;
    logic                     pp_illegal;

    assign cur_digit = dig_q[cnt_q];

    booth_dec_r4 #(
        .WIDTH  (WIDTH),
        .PWIDTH (PWIDTH)
    ) u_dec (
        .digit   (cur_digit),
        .a       (a_q),
        .pp      (pp),
        .illegal (pp_illegal)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = acc_q;
    assign err       = err_q;

    // Next-state logic for the FSM, counter, operand registers and accumulator.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        dig_d       = dig_q;
        acc_d       = acc_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    dig_d      = dig;
                    acc_d      = '0;
                    err_d      = 1'b0;
                    cnt_d      = CW'(NDIG - 1);
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = {acc_q[PWIDTH-3:0], 2'b00} + pp;
                err_d = err_q | pp_illegal;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            dig_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            dig_q       <= dig_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_booth_r4_pp_accum.sv
// Scoreboard bench for booth_r4_pp_accum with WIDTH=8, NDIG=5 (PWIDTH=19).
// Expected products are hand-computed constants; a monitor thread pops them
// whenever the DUT completes an output handshake.
module tb_booth_r4_pp_accum;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NDIG   = 5;
    localparam int unsigned PWIDTH = 19;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a;
    logic [3*NDIG-1:0]   dig;
    logic                out_valid;
    logic                out_ready;
    logic [PWIDTH-1:0]   product;
    logic                err;

    booth_r4_pp_accum #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .dig       (dig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [3*NDIG-1:0]  dig;
        logic [PWIDTH-1:0]  p;
        logic               e;
    } vec_t;

    typedef struct {
        logic [PWIDTH-1:0]  p;
        logic               e;
    } exp_t;

    vec_t  vecs [11];
    exp_t  sb [$];
    int    checks;
    int    failures;
    bit    stim_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) chk({name, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    // Offer a vector, push its expectation, and return one cycle after the accept edge.
    task automatic send(input int idx);
        exp_t x;
        wait_ready($sformatf("send%0d", idx));
        in_valid = 1'b1;
        a        = vecs[idx].a;
        dig      = vecs[idx].dig;
        x.p      = vecs[idx].p;
        x.e      = vecs[idx].e;
        sb.push_back(x);
        step();
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        dig      = (3*NDIG)'($urandom);
    endtask

    initial begin
        int   n;
        exp_t got;

        // digits packed {d4,d3,d2,d1,d0}
        vecs[0]  = '{8'hFF, 15'b001_000_000_000_111, 19'h0FE01, 1'b0}; // 255*255
        vecs[1]  = '{8'h03, 15'b111_111_111_111_111, 19'h7FC01, 1'b0}; // 3*-341
        vecs[2]  = '{8'h00, 15'b010_111_001_110_010, 19'h00000, 1'b0};
        vecs[3]  = '{8'h80, 15'b000_000_000_000_010, 19'd256,   1'b0};
        vecs[4]  = '{8'h01, 15'b000_000_011_000_000, 19'h00000, 1'b1};
        vecs[5]  = '{8'h01, 15'b000_000_000_001_001, 19'd5,     1'b0};
        vecs[6]  = '{8'hFF, 15'b010_010_010_010_010, 19'h2A756, 1'b0}; // 255*682
        vecs[7]  = '{8'hFF, 15'b110_110_110_110_110, 19'h558AA, 1'b0}; // 255*-682
        vecs[8]  = '{8'h05, 15'b110_010_111_001_000, 19'h7F844, 1'b0}; // 5*-396
        vecs[9]  = '{8'h07, 15'b000_000_100_001_101, 19'd28,    1'b1};
        vecs[10] = '{8'hFF, 15'b100_010_010_010_010, 19'h00000, 1'b1}; // aborted by reset

        checks    = 0;
        failures  = 0;
        stim_done = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        dig       = '0;

        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        fork
            begin : stim
                // Latency: out_valid appears after exactly NDIG edges past the accept edge.
                send(0);
                wait_valid("latency", n);
                chk("latency_edges", 32'(n), 32'(NDIG));

                send(1);
                chk("in_ready_run", 32'(in_ready), 32'd0);
                for (int i = 2; i <= 5; i++) send(i);
                send(7);
                send(9);

                // Backpressure: result held, new offers ignored.
                wait_ready("bp_pre");
                out_ready = 1'b0;
                send(6);
                wait_valid("bp", n);
                for (int k = 0; k < 5; k++) begin
                    in_valid = (k % 2 == 0);
                    a        = WIDTH'($urandom);
                    dig      = (3*NDIG)'($urandom);
                    step();
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_product", 32'(product), 32'h2A756);
                    chk("bp_err", 32'(err), 32'd0);
                end
                // in_valid during the completing handshake is not taken until IDLE.
                out_ready = 1'b1;
                in_valid  = 1'b1;
                a         = vecs[1].a;
                dig       = vecs[1].dig;
                step();
                chk("hs_idle_in_ready", 32'(in_ready), 32'd1);
                chk("hs_idle_out_valid", 32'(out_valid), 32'd0);
                got.p = vecs[1].p;
                got.e = vecs[1].e;
                sb.push_back(got);
                step();
                in_valid = 1'b0;
                chk("hs_accepted", 32'(in_ready), 32'd0);

                // Reset abort at RUN cnt==2.
                send(10);
                step();
                step();
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                void'(sb.pop_back());
                chk("abort_in_ready", 32'(in_ready), 32'd1);
                chk("abort_out_valid", 32'(out_valid), 32'd0);
                chk("abort_product", 32'(product), 32'd0);
                chk("abort_err", 32'(err), 32'd0);
                send(8);
                send(9);
                wait_ready("drain");
                repeat (2) step();
                stim_done = 1'b1;
            end
            begin : monitor
                while (!stim_done) begin
                    @(negedge clk);
                    if (rst_n && out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_output", 32'd1, 32'd0);
                        end else begin
                            got = sb.pop_front();
                            chk("product", 32'(product), 32'(got.p));
                            chk("err", 32'(err), 32'(got.e));
                        end
                    end
                end
            end
        join

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
